// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// default widths and the opcode fields that identify a halt instruction.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 9;

  localparam logic [3:0] SPEC_OP  = 4'b0111;
  localparam logic [2:0] HLT_FUNC = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [3:0] op, input logic [2:0] func);
    return (op == SPEC_OP) && (func == HLT_FUNC);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: requests imem at pc, holds the word for
// decode, then advances or redirects pc. FETCH_INSTR_COUNT_EN adds an issue counter.
//
// Handshakes: imem side completes in the cycle imem_req && imem_ack are both high;
// decode side completes in the cycle instr_valid && instr_ready are both high.
// Neither valid output depends combinationally on the matching ready/ack input.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [15:0]        instr_count,
  output logic [1:0]         fsm_state
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               handshake;
  logic               halt_instr;

  assign handshake  = (state_q == HOLD) && instr_ready;
  assign halt_instr = is_halt(instr_q[8:5], instr_q[2:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (imem_ack) state_d = HOLD;
      HOLD:    if (instr_ready) state_d = halt_instr ? HALT : WAIT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == WAIT) && imem_ack)
        instr_q <= imem_rdata;
      // A halt leaves pc pointing at itself so the stop address is visible.
      if (handshake && !halt_instr)
        pc_q <= redirect_valid ? redirect_pc : pc_q + PC_W'(1);
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (handshake && (count_q != 16'hFFFF))
      count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'd0;
`endif

  assign imem_req    = (state_q == WAIT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALT);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch/hold, redirect, pc wrap, halt,
// and reset abandoning an outstanding request.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [8:0]  imem_rdata;
  logic [8:0]  instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] instr_count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .halted         (halted),
    .instr_count    (instr_count),
    .fsm_state      (fsm_state)
  );

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef FETCH_INSTR_COUNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   16'(imem_req),    16'd0);
    check({tag, "_pc"},    16'(pc),          16'd0);
    check({tag, "_instr"}, 16'(instruction), 16'd0);
    check({tag, "_valid"}, 16'(instr_valid), 16'd0);
    check({tag, "_halt"},  16'(halted),      16'd0);
    check({tag, "_cnt"},   instr_count,      16'd0);
  endtask

  // Complete a fetch from WAIT: ack with word, then expect it presented.
  task automatic ack_word(input string tag, input logic [8:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 9'h000;
    check({tag, "_valid"}, 16'(instr_valid), 16'd1);
    check({tag, "_instr"}, 16'(instruction), 16'(word));
    check({tag, "_req0"},  16'(imem_req),    16'd0);
  endtask

  // Handshake in HOLD, optionally redirecting, then expect the next request.
  task automatic accept(input string tag, input logic redir, input logic [7:0] target,
                        input logic [7:0] exp_addr, input int exp_n);
    instr_ready    = 1'b1;
    redirect_valid = redir;
    redirect_pc    = target;
    step();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    check({tag, "_req"},   16'(imem_req),    16'd1);
    check({tag, "_addr"},  16'(imem_addr),   16'(exp_addr));
    check({tag, "_valid"}, 16'(instr_valid), 16'd0);
    check({tag, "_cnt"},   instr_count,      exp_cnt(exp_n));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 9'h000;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    step();
    check_reset_values("rst");
    reset = 1'b0;
    step();
    check("idle_req", 16'(imem_req), 16'd0);

    // Start, then two cycles of waiting before the ack arrives.
    start = 1'b1;
    step();
    start = 1'b0;
    check("wait_req",  16'(imem_req),  16'd1);
    check("wait_addr", 16'(imem_addr), 16'd0);
    step();
    check("wait2_req",   16'(imem_req),    16'd1);
    check("wait2_addr",  16'(imem_addr),   16'd0);
    check("wait2_valid", 16'(instr_valid), 16'd0);
    ack_word("f0", 9'h000);

    // Decode stalls for three cycles; a stray ack must not disturb the word.
    imem_ack = 1'b1; imem_rdata = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 16'(instr_valid), 16'd1);
      check("hold_instr", 16'(instruction), 16'h000);
      check("hold_req",   16'(imem_req),    16'd0);
    end
    imem_ack = 1'b0; imem_rdata = 9'h000;
    accept("a0", 1'b0, 8'h00, 8'h01, 1);

    // Redirect presented while waiting is ignored.
    redirect_valid = 1'b1; redirect_pc = 8'h77;
    step();
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    check("wait_redir_addr", 16'(imem_addr), 16'h01);
    ack_word("f1", 9'h0A5);
    accept("a1", 1'b1, 8'h40, 8'h40, 2);

    // Redirect to the top address, then fall through and wrap to zero.
    ack_word("f2", 9'h1F0);
    accept("a2", 1'b1, 8'hFF, 8'hFF, 3);
    ack_word("f3", 9'h123);
    accept("a3", 1'b0, 8'h00, 8'h00, 4);

    // Same opcode as halt but different func field: ordinary instruction.
    ack_word("f4", 9'h0E3);
    accept("a4", 1'b0, 8'h00, 8'h01, 5);

    // Halt: 9'b0111_00_010.
    ack_word("f5", 9'h0E2);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h55;
    step();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    check("halt_halted", 16'(halted),      16'd1);
    check("halt_valid",  16'(instr_valid), 16'd0);
    check("halt_req",    16'(imem_req),    16'd0);
    check("halt_pc",     16'(pc),          16'h01);
    check("halt_cnt",    instr_count,      exp_cnt(6));
    start = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 9'h111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halted_stay", 16'(halted),   16'd1);
      check("halted_req",  16'(imem_req), 16'd0);
      check("halted_pc",   16'(pc),       16'h01);
      check("halted_cnt",  instr_count,   exp_cnt(6));
    end
    start = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = 9'h000;

    // Reset out of HALT, start a request, then reset asynchronously mid-wait.
    reset = 1'b1;
    #1;
    check_reset_values("rst_halt");
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst2_wait_req", 16'(imem_req), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_req", 16'(imem_req), 16'd0);
    step();
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 9'h1FF;
    step();
    imem_ack = 1'b0; imem_rdata = 9'h000;
    step();
    check_reset_values("post_ack");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
